if_fetch: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline. It holds the PC and runs a request/acknowledge handshake with the memory controller. It also owns the IF/ID pipeline register that feeds decode. It consumes `stall_i`, `flush_i` and the redirect (`set_pc_e_i`/`set_pc_i`) from the pipeline controller, and reports `if_stall_o` back to it. A redirect that lands while a memory request is outstanding is absorbed: the stale word is discarded, never issued.

---
 rtl/if_fetch.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, memory request/ack handshake, one-word skid buffer
// and the IF/ID pipeline register feeding decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  stall_i,
  input  logic [4:0]  flush_i,
  input  logic        set_pc_e_i,
  input  logic [31:0] set_pc_i,
  output logic        if_stall_o,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        ack_i,
  input  logic [31:0] data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] pc_o_q, pc_o_d;
  logic [31:0] inst_o_q, inst_o_d;
  logic        valid_q, valid_d;
  logic        load;
  logic [31:0] load_pc, load_inst;
  logic        unused_bits;

  // Only stage 1 (IF/ID) of the controller vectors concerns this block.
  assign unused_bits = ^{stall_i[4:2], stall_i[0], flush_i[4:2], flush_i[0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    load       = 1'b0;
    load_pc    = pc_q;
    load_inst  = data_i;
    case (state_q)
      FETCH: begin
        addr_d = pc_q;
        if (set_pc_e_i) begin
          // An ack in the redirect cycle is dropped; otherwise the in-flight
          // request must still complete, so wait it out in DISCARD.
          pc_d    = set_pc_i;
          state_d = ack_i ? FETCH : DISCARD;
        end else if (ack_i) begin
          pc_d = pc_q + 32'd4;
          if (stall_i[1]) begin
            buf_inst_d = data_i;
            buf_pc_d   = pc_q;
            state_d    = HOLD;
          end else begin
            load      = 1'b1;
            load_pc   = pc_q;
            load_inst = data_i;
          end
        end
      end
      HOLD: begin
        if (set_pc_e_i) begin
          pc_d    = set_pc_i;
          state_d = FETCH;
        end else if (!stall_i[1]) begin
          load      = 1'b1;
          load_pc   = buf_pc_q;
          load_inst = buf_inst_q;
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        if (set_pc_e_i) pc_d = set_pc_i;
        if (ack_i) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    valid_d  = valid_q;
    pc_o_d   = pc_o_q;
    inst_o_d = inst_o_q;
    if (flush_i[1]) begin
      valid_d = 1'b0;
    end else if (!stall_i[1]) begin
      if (load) begin
        valid_d  = 1'b1;
        pc_o_d   = load_pc;
        inst_o_d = load_inst;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      buf_inst_q <= 32'h0;
      buf_pc_q   <= 32'h0;
      valid_q    <= 1'b0;
      pc_o_q     <= 32'h0;
      inst_o_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      valid_q    <= valid_d;
      pc_o_q     <= pc_o_d;
      inst_o_q   <= inst_o_d;
    end
  end

  assign req_o      = rst_n && (state_q != HOLD);
  assign addr_o     = (state_q == DISCARD) ? addr_q : pc_q;
  assign if_stall_o = rst_n && (((state_q == FETCH) && !ack_i) || (state_q == DISCARD));
  assign pc_o       = pc_o_q;
  assign inst_o     = inst_o_q;
  assign valid_o    = valid_q;

endmodule
